// File: rtl/dds_tone_sequencer.sv
// Tone-index FIFO and symbol-period sequencer driving the DDS phase-increment input.
// Optional DDS_SEQ_SYMCNT_EN adds sym_count_o, a 16-bit count of symbols issued since the last start.
module dds_tone_sequencer #(
  parameter int PHASE_W    = 25,
  parameter int TONE_W     = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 24
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [PHASE_W-1:0]            base_phase_i,
  input  logic [PHASE_W-1:0]            tone_step_i,
  input  logic [CNT_W-1:0]              sym_period_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          sym_valid_i,
  output logic                          sym_ready_o,
  input  logic [TONE_W-1:0]             sym_i,
  input  logic                          sym_last_i,
  output logic [PHASE_W-1:0]            phase_o,
  output logic                          phase_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
`ifdef DDS_SEQ_SYMCNT_EN
  ,
  output logic [15:0]                   sym_count_o
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  // state | meaning
  // IDLE  | carrier at base_phase_i, waiting for start
  // WAIT  | transmission active, FIFO empty, phase held
  // RUN   | symbol period counting
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;
  state_t state, state_nxt;

  logic [TONE_W:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     count;
  logic                 push, pop, empty;
  logic [TONE_W-1:0]    head_tone;
  logic                 head_last;

  logic [PHASE_W-1:0]   base_l, step_l;
  logic [CNT_W-1:0]     period_l, cnt;
  logic                 cur_last;

  logic [PHASE_W-1:0]   src_base, src_step, phase_nxt;
  logic [CNT_W-1:0]     src_period;
  logic                 valid_nxt, done_nxt, load, start_acc, underrun_set;

  assign empty       = (count == '0);
  assign sym_ready_o = (count != LVL_W'(FIFO_DEPTH));
  assign push        = sym_valid_i && sym_ready_o && !abort_i;
  assign {head_last, head_tone} = mem[rd_ptr];
  assign level_o     = count;
  assign busy_o      = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {sym_last_i, sym_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (pop && !push) count <= count - LVL_W'(1);
    end
  end

  // Start acceptance uses the live inputs; later symbols use the values latched then.
  always_comb begin
    src_base   = (state == S_IDLE) ? base_phase_i : base_l;
    src_step   = (state == S_IDLE) ? tone_step_i  : step_l;
    src_period = (state == S_IDLE) ? sym_period_i : period_l;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    load         = 1'b0;
    start_acc    = 1'b0;
    underrun_set = 1'b0;
    phase_nxt    = phase_o;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    if (abort_i) begin
      state_nxt = S_IDLE;
      phase_nxt = base_phase_i;
      valid_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          phase_nxt = base_phase_i;
          valid_nxt = 1'b1;
          if (start_i) begin
            start_acc = 1'b1;
            if (!empty) begin
              pop       = 1'b1;
              load      = 1'b1;
              state_nxt = S_RUN;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!empty) begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            if (cur_last) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
              phase_nxt = base_l;
              valid_nxt = 1'b1;
            end else if (!empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              underrun_set = 1'b1;
              state_nxt    = S_WAIT;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    if (load) begin
      phase_nxt = src_base + PHASE_W'(head_tone) * src_step;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      phase_o       <= '0;
      phase_valid_o <= 1'b0;
      done_o        <= 1'b0;
      underrun_o    <= 1'b0;
      base_l        <= '0;
      step_l        <= '0;
      period_l      <= '0;
      cnt           <= '0;
      cur_last      <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase_o       <= phase_nxt;
      phase_valid_o <= valid_nxt;
      done_o        <= done_nxt;
      if (start_acc) begin
        base_l   <= base_phase_i;
        step_l   <= tone_step_i;
        period_l <= sym_period_i;
      end
      if (start_acc)         underrun_o <= 1'b0;
      else if (underrun_set) underrun_o <= 1'b1;
      if (load) begin
        cnt      <= src_period - CNT_W'(1);
        cur_last <= head_last;
      end else if (state == S_RUN && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef DDS_SEQ_SYMCNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          sym_count_o <= '0;
    else if (start_acc) sym_count_o <= pop ? 16'd1 : 16'd0;
    else if (pop)       sym_count_o <= sym_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dds_tone_sequencer.sv
// Self-checking bench for dds_tone_sequencer: vector table plus scoreboarded symbol sequences.
module tb_dds_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] base_phase = '0, tone_step = '0;
  logic [23:0] sym_period = 24'd2;
  logic        start = 1'b0, abort_s = 1'b0, sym_valid = 1'b0, sym_last = 1'b0;
  logic [2:0]  sym = '0;
  logic        sym_ready, phase_valid, busy, done, underrun;
  logic [24:0] phase;
  logic [4:0]  level;
`ifdef DDS_SEQ_SYMCNT_EN
  logic [15:0] sym_count;
`endif

  dds_tone_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .base_phase_i(base_phase), .tone_step_i(tone_step), .sym_period_i(sym_period),
    .start_i(start), .abort_i(abort_s),
    .sym_valid_i(sym_valid), .sym_ready_o(sym_ready), .sym_i(sym), .sym_last_i(sym_last),
    .phase_o(phase), .phase_valid_o(phase_valid), .busy_o(busy), .done_o(done),
    .underrun_o(underrun), .level_o(level)
`ifdef DDS_SEQ_SYMCNT_EN
    , .sym_count_o(sym_count)
`endif
  );

  always #8 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of issued symbol phases; gap is the required spacing from the previous strobe (0 = unchecked).
  typedef struct { logic [24:0] ph; int gap; } exp_t;
  exp_t sb[$];
  bit          mon_en = 1'b0;
  int          last_cyc = 0;
  logic [24:0] last_phase = '0;

  always @(posedge clk) begin
    #1;
    if (mon_en && busy) begin
      if (phase_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_phase", phase, e.ph);
          if (e.gap != 0) check("sb_gap", cyc - last_cyc, e.gap);
        end
        last_cyc   = cyc;
        last_phase = phase;
      end else if (phase !== last_phase) begin
        check("phase_hold", phase, last_phase);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sym(input logic [2:0] t, input logic l);
    sym_valid = 1'b1; sym = t; sym_last = l;
    tick();
    sym_valid = 1'b0; sym_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    check("done_seen", ok, 1);
  endtask

  typedef struct {
    logic [24:0] base;
    logic [24:0] step;
    logic [2:0]  tone;
    logic [24:0] exp_ph;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{25'd33554430, 25'd3,        3'd1, 25'd1};
    vecs[1] = '{25'd0,        25'h1FFFFFF,  3'd7, 25'd33554425};
    vecs[2] = '{25'd100,      25'd1000,     3'd5, 25'd5100};
    vecs[3] = '{25'd3797825,  25'd4,        3'd0, 25'd3797825};
    vecs[4] = '{25'd16777216, 25'd16777216, 3'd3, 25'd0};
    vecs[5] = '{25'd12345,    25'd11184810, 3'd6, 25'd12341};

    // Reset values and idle carrier
    base_phase = 25'd3797825; tone_step = 25'd4; sym_period = 24'd4;
    tick();
    check("rst_phase", phase, 0);
    check("rst_valid", phase_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_ready", sym_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_phase", phase, 3797825);
      check("idle_valid", phase_valid, 1);
      check("idle_busy", busy, 0);
    end

    // Basic three-symbol transmission
    push_sym(3'd0, 1'b0);
    push_sym(3'd3, 1'b0);
    push_sym(3'd1, 1'b1);
    check("basic_level", level, 3);
    sb.push_back('{25'd3797825, 0});
    sb.push_back('{25'd3797837, 4});
    sb.push_back('{25'd3797829, 4});
    mon_en = 1'b1;
    pulse_start();
    check("basic_first_busy", busy, 1);
    wait_done(40);
    check("basic_done_gap", cyc - last_cyc, 4);
    check("basic_end_phase", phase, 3797825);
    check("basic_end_valid", phase_valid, 1);
    check("basic_end_busy", busy, 0);
    check("basic_sb_drain", sb.size(), 0);
    tick();
    check("basic_done_pulse", done, 0);
`ifdef DDS_SEQ_SYMCNT_EN
    check("basic_sym_count", sym_count, 3);
`endif

    // Underrun, then resume from WAIT
    sym_period = 24'd3;
    push_sym(3'd2, 1'b0);
    sb.push_back('{25'd3797833, 0});
    pulse_start();
    tick(); tick();
    check("ur_early", underrun, 0);
    tick();
    check("ur_set", underrun, 1);
    check("ur_busy", busy, 1);
    check("ur_valid", phase_valid, 0);
    check("ur_phase", phase, 3797833);
    tick(); tick(); tick();
    check("ur_hold", phase, 3797833);
    sb.push_back('{25'd3797845, 0});
    push_sym(3'd5, 1'b1);
    check("ur_not_yet", phase_valid, 0);
    tick();
    check("ur_resume_phase", phase, 3797845);
    check("ur_resume_valid", phase_valid, 1);
    wait_done(20);
    check("ur_sticky", underrun, 1);
    check("ur_sb_drain", sb.size(), 0);

    // FIFO full, rejected 17th symbol, drain one entry per period
    base_phase = 25'd1000; tone_step = 25'd7; sym_period = 24'd4;
    for (int i = 0; i < 16; i++) begin
      push_sym(3'(i % 8), i == 15);
      sb.push_back('{25'(1000 + 7 * (i % 8)), (i == 0) ? 0 : 4});
    end
    check("full_level", level, 16);
    check("full_ready", sym_ready, 0);
    push_sym(3'd7, 1'b0);
    check("full_reject", level, 16);
    pulse_start();
    check("start_clr_underrun", underrun, 0);
    check("drain_level_0", level, 15);
    repeat (4) tick();
    check("drain_level_1", level, 14);
    repeat (4) tick();
    check("drain_level_2", level, 13);
    wait_done(80);
    check("full_sb_drain", sb.size(), 0);
    check("full_end_level", level, 0);
    mon_en = 1'b0;

    // Abort mid-RUN with a simultaneous push
    base_phase = 25'd3797825; tone_step = 25'd4; sym_period = 24'd10;
    push_sym(3'd1, 1'b0);
    push_sym(3'd2, 1'b0);
    push_sym(3'd3, 1'b1);
    pulse_start();
    tick(); tick(); tick();
    check("abort_pre_busy", busy, 1);
    abort_s = 1'b1; sym_valid = 1'b1; sym = 3'd4;
    tick();
    abort_s = 1'b0; sym_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_level", level, 0);
    check("abort_phase", phase, 3797825);
    check("abort_valid", phase_valid, 1);
    begin
      bit saw;
      saw = done;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (done) saw = 1'b1;
      end
      check("abort_no_done", saw, 0);
      check("abort_stays_idle", busy, 0);
    end

    // Arithmetic vectors, including mod-2^25 wrap
    sym_period = 24'd2;
    for (int v = 0; v < 6; v++) begin
      base_phase = vecs[v].base;
      tone_step  = vecs[v].step;
      push_sym(vecs[v].tone, 1'b1);
      pulse_start();
      check("vec_phase", phase, vecs[v].exp_ph);
      check("vec_valid", phase_valid, 1);
      wait_done(10);
      check("vec_end_phase", phase, vecs[v].base);
    end

    // Asynchronous reset mid-transmission
    push_sym(3'd4, 1'b1);
    sym_period = 24'd20;
    pulse_start();
    tick();
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_phase", phase, 0);
    check("async_rst_level", level, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
